// File: rtl/lfi_pkg.sv
// Purpose: shared widths, rate-port state encoding and saturating add for the Lfi spike decoder.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package lfi_pkg;

    localparam int            CURRENT_W   = 8;
    localparam logic [7:0]    CURRENT_MAX = 8'hFF;

    typedef enum logic {
        RATE_EMPTY = 1'b0,
        RATE_FULL  = 1'b1
    } rate_state_e;

    // 8-bit unsigned add that clamps at CURRENT_MAX instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? CURRENT_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/lfi_syn_current.sv
// Purpose: spike rising-edge detect plus leaky, saturating synaptic-current integrator.
// Latency: event in cycle n shows on current_o in cycle n+1; evt_o is same-cycle, internal use only.
// Backpressure: none; accepts a spike sample every cycle.
module lfi_syn_current
    import lfi_pkg::*;
#(
    parameter int DECAY_SHIFT = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 spike_i,
    input  logic [CURRENT_W-1:0] weight_i,
    output logic [CURRENT_W-1:0] current_o,
    output logic                 evt_o
);

    logic                 spike_q;
    logic [CURRENT_W-1:0] cur_q;
    logic [CURRENT_W-1:0] cur_d;
    logic [CURRENT_W-1:0] dec;
    logic [CURRENT_W-1:0] add;

    assign evt_o = spike_i & ~spike_q;

    // Leak is at least 1 while nonzero so small currents drain to 0 instead of stalling.
    always_comb begin
        dec = cur_q >> DECAY_SHIFT;
        if (dec == '0 && cur_q != '0) begin
            dec = 8'd1;
        end
        add   = (evt_o & en_i) ? weight_i : '0;
        cur_d = sat_add8(cur_q - dec, add);
    end

    // Spike history tracks the line even while disabled; current leaks every cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            spike_q <= 1'b0;
            cur_q   <= '0;
        end else begin
            spike_q <= spike_i;
            cur_q   <= cur_d;
        end
    end

    assign current_o = cur_q;

endmodule

// File: rtl/lfi_spike_decoder.sv
// Purpose: turns an Lfi spike train into a synaptic current and a windowed spike-rate count.
// Latency: current_o 1 cycle after the event; rate_o/rate_valid_o 1 cycle after the window's last cycle.
// Backpressure: valid/ready on rate_o; an unaccepted result is overwritten at the next window close and overrun_o latches.
module lfi_spike_decoder
    import lfi_pkg::*;
#(
    parameter int WINDOW_CYCLES = 256,
    parameter int DECAY_SHIFT   = 3,
    parameter int CNT_W         = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 spike_i,
    input  logic [CURRENT_W-1:0] weight_i,
    output logic [CURRENT_W-1:0] current_o,
    output logic [CNT_W-1:0]     rate_o,
    output logic                 rate_valid_o,
    input  logic                 rate_ready_i,
    output logic                 overrun_o
);

    localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic              evt;
    logic              cnt_evt;
    logic              terminal;

    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  spk_cnt_q, spk_cnt_d;
    logic [CNT_W-1:0]  spk_cnt_inc;
    logic [CNT_W-1:0]  rate_q, rate_d;
    logic              overrun_q, overrun_d;
    rate_state_e       state_q, state_d;

    lfi_syn_current #(
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_syn_current (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .spike_i   (spike_i),
        .weight_i  (weight_i),
        .current_o (current_o),
        .evt_o     (evt)
    );

    assign cnt_evt  = evt & en_i;
    assign terminal = en_i & (win_cnt_q == WIN_LAST);

    // Spike count including this cycle's event, held at all-ones once full.
    always_comb begin
        spk_cnt_inc = spk_cnt_q;
        if (cnt_evt && spk_cnt_q != '1) begin
            spk_cnt_inc = spk_cnt_q + CNT_W'(1);
        end
    end

    // Window bookkeeping: advance only when enabled; the closing cycle's event stays in the closing window.
    always_comb begin
        win_cnt_d = win_cnt_q;
        spk_cnt_d = spk_cnt_q;
        if (terminal) begin
            win_cnt_d = '0;
            spk_cnt_d = '0;
        end else if (en_i) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            spk_cnt_d = spk_cnt_inc;
        end
    end

    // Rate port FSM: a closing window always loads rate; overwriting an unaccepted result flags overrun.
    always_comb begin
        state_d   = state_q;
        rate_d    = rate_q;
        overrun_d = overrun_q;
        case (state_q)
            RATE_EMPTY: begin
                if (terminal) begin
                    state_d = RATE_FULL;
                    rate_d  = spk_cnt_inc;
                end
            end
            RATE_FULL: begin
                if (terminal) begin
                    rate_d = spk_cnt_inc;
                    if (!rate_ready_i) begin
                        overrun_d = 1'b1;
                    end
                end else if (rate_ready_i) begin
                    state_d = RATE_EMPTY;
                end
            end
            default: state_d = RATE_EMPTY;
        endcase
    end

    // State registers; reset drops any partial window.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
            spk_cnt_q <= '0;
            rate_q    <= '0;
            overrun_q <= 1'b0;
            state_q   <= RATE_EMPTY;
        end else begin
            win_cnt_q <= win_cnt_d;
            spk_cnt_q <= spk_cnt_d;
            rate_q    <= rate_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
        end
    end

    assign rate_o       = rate_q;
    assign rate_valid_o = (state_q == RATE_FULL);
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_lfi_spike_decoder.sv
// Purpose: directed self-checking bench for lfi_spike_decoder (16-cycle window, shift-3 leak).
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: rate_ready_i driven directly by the stimulus.
module tb_lfi_spike_decoder;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_i = 1'b1;
    logic       spike_i = 1'b0;
    logic [7:0] weight_i = 8'd0;
    logic [7:0] current_o;
    logic [7:0] rate_o;
    logic       rate_valid_o;
    logic       rate_ready_i = 1'b1;
    logic       overrun_o;

    int tests_run = 0;
    int tests_failed = 0;

    lfi_spike_decoder #(
        .WINDOW_CYCLES (16),
        .DECAY_SHIFT   (3),
        .CNT_W         (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .spike_i      (spike_i),
        .weight_i     (weight_i),
        .current_o    (current_o),
        .rate_o       (rate_o),
        .rate_valid_o (rate_valid_o),
        .rate_ready_i (rate_ready_i),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input logic sp);
        spike_i = sp;
        tick();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        spike_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Hand-computed leak trace for one 32-unit event with shift 3.
    int decay_exp [23] = '{32, 28, 25, 22, 20, 18, 16, 14, 13, 12, 11, 10,
                           9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
    int sat_exp [8] = '{200, 175, 255, 224, 255, 224, 255, 224};
    int t6_cur_exp [8] = '{40, 35, 71, 63, 96, 84, 74, 65};

    initial begin
        // 1: reset holds every output at 0 despite spikes and ready
        rst_n        = 1'b0;
        weight_i     = 8'd50;
        rate_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            spike_i = k[0];
            tick();
            chk("rst_current", current_o, 0);
            chk("rst_rate", rate_o, 0);
            chk("rst_valid", rate_valid_o, 0);
            chk("rst_overrun", overrun_o, 0);
        end
        spike_i = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk("rel_current", current_o, 0);
        chk("rel_rate", rate_o, 0);
        chk("rel_valid", rate_valid_o, 0);
        chk("rel_overrun", overrun_o, 0);

        // 2: single spike, weight 32, leak down to 0
        do_reset();
        weight_i = 8'd32;
        for (int k = 0; k < 23; k++) begin
            step(k == 0);
            chk($sformatf("decay[%0d]", k), current_o, decay_exp[k]);
        end

        // 3: weight 200 every other cycle clamps at 255
        do_reset();
        weight_i = 8'd200;
        for (int k = 0; k < 8; k++) begin
            step(k % 2 == 0);
            chk($sformatf("sat[%0d]", k), current_o, sat_exp[k]);
        end

        // 4: 16-cycle window, events at 0,2,4,6, held 8..10, terminal 15
        do_reset();
        weight_i     = 8'd1;
        rate_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(k == 0 || k == 2 || k == 4 || k == 6 || (k >= 8 && k <= 10) || k == 15);
            if (k == 14) chk("w4_valid_before", rate_valid_o, 0);
        end
        chk("w4_valid", rate_valid_o, 1);
        chk("w4_rate", rate_o, 6);
        step(1'b0);
        chk("w4_valid_after", rate_valid_o, 0);
        chk("w4_overrun", overrun_o, 0);

        // 5: ready low across two windows, 3 then 7 events
        do_reset();
        rate_ready_i = 1'b0;
        for (int k = 0; k < 32; k++) begin
            step((k < 16) ? (k == 0 || k == 2 || k == 4) : (k % 2 == 0 && k <= 28));
            if (k == 15) begin
                chk("w5_rate1", rate_o, 3);
                chk("w5_valid1", rate_valid_o, 1);
                chk("w5_ovr1", overrun_o, 0);
            end
            if (k == 20) chk("w5_rate_hold", rate_o, 3);
        end
        chk("w5_rate2", rate_o, 7);
        chk("w5_ovr2", overrun_o, 1);
        step(1'b0);
        step(1'b0);
        chk("w5_rate_stable", rate_o, 7);
        chk("w5_valid_stable", rate_valid_o, 1);
        rate_ready_i = 1'b1;
        step(1'b0);
        chk("w5_valid_drop", rate_valid_o, 0);
        chk("w5_ovr_sticky", overrun_o, 1);

        // 6: en_i low for 10 mid-window cycles, then reset mid-window
        do_reset();
        weight_i     = 8'd40;
        rate_ready_i = 1'b1;
        for (int k = 0; k < 26; k++) begin
            en_i = !(k >= 5 && k <= 14);
            if (k <= 4)       spike_i = (k % 2 == 0);
            else if (k <= 14) spike_i = (k % 2 == 1);
            else              spike_i = (k == 20);
            tick();
            if (k < 8) chk($sformatf("w6_cur[%0d]", k), current_o, t6_cur_exp[k]);
            if (k == 15) chk("w6_no_early_close", rate_valid_o, 0);
            if (k == 24) chk("w6_valid_before", rate_valid_o, 0);
        end
        chk("w6_valid", rate_valid_o, 1);
        chk("w6_rate", rate_o, 4);
        en_i = 1'b1;
        for (int k = 0; k < 5; k++) step(k == 1 || k == 3);
        chk("w6_valid_acc", rate_valid_o, 0);
        do_reset();
        chk("w6_rst_rate", rate_o, 0);
        chk("w6_rst_valid", rate_valid_o, 0);
        for (int k = 0; k < 16; k++) step(k == 3);
        chk("w6_post_rst_valid", rate_valid_o, 1);
        chk("w6_post_rst_rate", rate_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
